// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: shared CPU constants for ALU codes, ALUOp classes, funct fields and issue FSM states.
package alu_issue_stage_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_MUL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_HOLD = 1'b1
    } issue_state_e;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: maps main-control ALUOp and R-type funct to the 3-bit ALU code plus an illegal flag.
module alu_ctrl_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       illegal_o
);
    logic [2:0] rtype_ctrl;
    logic       rtype_illegal;

    always_comb begin
        rtype_ctrl    = ALU_ADD;
        rtype_illegal = 1'b0;
        case (funct_i)
            FUNCT_ADD: rtype_ctrl = ALU_ADD;
            FUNCT_SUB: rtype_ctrl = ALU_SUB;
            FUNCT_AND: rtype_ctrl = ALU_AND;
            FUNCT_OR:  rtype_ctrl = ALU_OR;
            FUNCT_MUL: rtype_ctrl = ALU_MUL;
            default:   rtype_illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_ctrl_o = (alu_op_i == ALUOP_BEQ)   ? ALU_SUB :
                     (alu_op_i == ALUOP_ORI)   ? ALU_OR  :
                     (alu_op_i == ALUOP_RTYPE) ? rtype_ctrl : ALU_ADD;
        illegal_o  = (alu_op_i == ALUOP_RTYPE) && rtype_illegal;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register feeding the ALU; decodes the ALU code, muxes operand 2
// and holds multiplies in EX for MUL_CYCLES cycles while stalling upstream.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [5:0]  funct_i,
    input  logic        ALUSrc_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [31:0] imm_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [2:0]  ALUCtrl_o,
    output logic        valid_o,
    output logic        illegal_o,
    output logic        stall_o
);
    localparam logic [3:0] HOLD_INIT = 4'(MUL_CYCLES - 1);

    issue_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         illegal_q, illegal_d;
    logic [2:0]   ctrl_q, ctrl_d;
    logic [31:0]  data1_q, data1_d;
    logic [31:0]  data2_q, data2_d;
    logic [2:0]   dec_ctrl;
    logic         dec_illegal;

    alu_ctrl_decode u_decode (
        .alu_op_i  (ALUOp_i),
        .funct_i   (funct_i),
        .alu_ctrl_o(dec_ctrl),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        if (flush_i) begin
            state_d   = RUN;
            cnt_d     = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (stall_i) begin
            state_d = state_q;
        end else if (state_q == MUL_HOLD) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RUN : MUL_HOLD;
        end else begin
            valid_d = valid_i;
            if (valid_i) begin
                illegal_d = dec_illegal;
                ctrl_d    = dec_ctrl;
                data1_d   = data1_i;
                data2_d   = ALUSrc_i ? imm_i : data2_i;
                // MUL_CYCLES==1 means a mul completes like any other op
                if (dec_ctrl == ALU_MUL && MUL_CYCLES > 1) begin
                    state_d = MUL_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= ALU_ADD;
            data1_q   <= '0;
            data2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
        end
    end

    assign data1_o   = data1_q;
    assign data2_o   = data2_q;
    assign ALUCtrl_o = ctrl_q;
    assign valid_o   = valid_q;
    assign illegal_o = illegal_q;
    assign stall_o   = (state_q == MUL_HOLD);
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue register for the pipelined CPU datapath; it drives the ALU's operand and 3-bit control inputs.
- Registers the decoded operands.
- Translates the main-control ALUOp plus R-type funct into the ALU control code.
- Selects the immediate or register second operand.
- Holds a multiply in EX for a configurable number of cycles, raising a stall to the upstream stages while it does.

## Interface
Parameters:
- MUL_CYCLES, default 2: total cycles a mul occupies EX; legal range 1..15; 1 means no hold.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  ID presents an instruction this cycle.
- ALUOp_i  in  2  main-control ALU class.
- funct_i  in  6  instruction funct field.
- ALUSrc_i  in  1  1 selects imm_i as the second operand.
- data1_i  in  32  rs value.
- data2_i  in  32  rt value.
- imm_i  in  32  sign-extended immediate.
- stall_i  in  1  downstream (hazard unit) freeze request.
- flush_i  in  1  kill the instruction being loaded and any hold in progress.
- data1_o  out  32  registered ALU operand 1.
- data2_o  out  32  registered ALU operand 2.
- ALUCtrl_o  out  3  registered ALU code: 000 add, 001 mul, 010 sub, 011 and, 100 or.
- valid_o  out  1  EX holds a live instruction.
- illegal_o  out  1  the live instruction had an undecodable funct.
- stall_o  out  1  multiply hold active; upstream stages must freeze.

## Operation
Decode is combinational on the inputs and is registered on load:
- ALUOp 00 → add (lw/sw/addi).
- ALUOp 01 → sub (beq).
- ALUOp 11 → or (ori).
- ALUOp 10, decoded by funct:
  - 100000 → add.
  - 100010 → sub.
  - 100100 → and.
  - 100101 → or.
  - 011000 → mul.
  - Any other funct → ALUCtrl 000 with illegal set.

Operand 2 on load is imm_i when ALUSrc_i=1, otherwise data2_i.

The state machine has two states, RUN and MUL_HOLD, with a 4-bit hold counter cnt.

Per-edge priority, highest first:
1. Reset.
2. flush_i.
3. stall_i.
4. MUL_HOLD countdown.
5. Load.

Behaviour at each priority level:
- **Reset:**
  - All outputs go to 0; ALUCtrl_o=000.
  - State goes to RUN; cnt=0.
- **flush_i=1 (in any state):**
  - valid_o=0 and illegal_o=0.
  - State goes to RUN; cnt=0.
  - Data registers keep their values (don't care while valid_o=0).
- **stall_i=1 (no flush):** all registers hold, including cnt; there is no countdown.
- **RUN, load:**
  - valid_o is loaded from valid_i.
  - Operands, ALUCtrl and illegal are loaded from the inputs when valid_i=1.
  - If the loaded code is mul, valid_i=1 and MUL_CYCLES>1: go to MUL_HOLD with cnt=MUL_CYCLES-1.
- **MUL_HOLD:**
  - Each edge with no flush and no stall decrements cnt.
  - When cnt reaches 0, return to RUN.
  - EX registers hold throughout; new inputs are ignored.
- **stall_o:** combinational, equal to (state==MUL_HOLD).
- **Illegal instructions:** they still propagate with valid_o=1; trap handling is downstream.

## Timing
- Load latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Multiply occupancy:
  - A mul occupies EX for exactly MUL_CYCLES un-stalled cycles.
  - stall_o is high for MUL_CYCLES-1 cycles, starting the cycle after the load edge.
  - The next instruction loads on the edge where cnt goes 1→0 plus one. That is, the upstream must hold its instruction while stall_o=1, and it is captured on the first edge with stall_o=0.
- Back-to-back muls each get their full hold; no gap cycle is required beyond the hold.
- stall_i freezes the countdown; the hold length measured in un-stalled cycles is unchanged.
- flush_i during MUL_HOLD: stall_o drops after that edge and valid_o=0.
- Reset asserted mid-hold clears immediately (asynchronous); stall_o=0 while reset is low.

## Structure
- Shared CPU package holds:
  - ALU code constants: ALU_ADD=3'b000, ALU_MUL=3'b001, ALU_SUB=3'b010, ALU_AND=3'b011, ALU_OR=3'b100.
  - ALUOp class constants.
  - funct constants.
  - The RUN/MUL_HOLD state encoding.
- One natural sub-module: alu_ctrl_decode, purely combinational, mapping (ALUOp, funct) to (ALUCtrl, illegal). The issue stage instantiates it and adds the registers and FSM.

## Test plan
- **Reset:** pulse rst_i low mid-simulation with a mul in hold → after the edge all outputs are 0, stall_o=0, and state is RUN.
- **Decode sweep:**
  - Drive ALUOp=10 with each legal funct, valid_i=1, data1=7, data2=3 → ALUCtrl_o and data1_o/data2_o are correct one cycle later.
  - funct=000000 → ALUCtrl_o=000 with illegal_o=1.
- **ALUSrc:** ALUOp=00, ALUSrc=1, imm=0xFFFFFFFC, data2=5 → data2_o=0xFFFFFFFC and ALUCtrl_o=000.
- **Mul hold (MUL_CYCLES=3):** mul followed by add →
  - stall_o is high for 2 cycles.
  - The add appears on the outputs after the third edge.
  - Also run with stall_i asserted for 1 cycle mid-hold → stall_o lasts 3 cycles.
- **Flush:** flush_i asserted the cycle after a mul load → valid_o=0 and stall_o=0 after that edge. Assert flush_i and stall_i together → flush wins.
- **Back-to-back muls (MUL_CYCLES=2):** → stall_o pattern is 1,0,1 and each mul is visible on the outputs for 2 cycles.
